lsu_bus_master: RTL

- Load/store initiator between the MEM pipeline stage and a shared, handshaked data-memory bus.
- Accepts one load or store per instruction from the MEM stage and stalls the pipeline until the bus completes it.
- Generates byte enables and lane-replicated write data; extracts and sign- or zero-extends load data.
- Memory is little-endian, byte-addressed; the bus is word-addressed (addr[1:0] = 0).

---
 rtl/lsu_bus_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: MEM-stage load/store initiator on a handshaked, word-addressed data bus
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_read, mem_write       request from MEM stage (write wins)
//   funct3, address           access size/sign and byte address
//   write_data                right-aligned store data
//   stall                     combinational pipeline freeze
//   load_data, load_valid     extended load result and its one-cycle strobe
//   misaligned                one-cycle strobe for a rejected access
//   bus_req/we/addr/be/wdata  bus request side
//   bus_gnt, bus_rvalid       bus acceptance and read-data strobes
//   bus_rdata                 bus read word
//   bus_error                 timeout strobe
// Optional: define LSU_TIMEOUT_EN to abort after TIMEOUT_CYCLES without gnt/rvalid.
module lsu_bus_master #(
    parameter int word_size      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [word_size-1:0] address,
    input  logic [word_size-1:0] write_data,
    output logic                 stall,
    output logic [word_size-1:0] load_data,
    output logic                 load_valid,
    output logic                 misaligned,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [word_size-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [word_size-1:0] bus_wdata,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [word_size-1:0] bus_rdata,
    output logic                 bus_error
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
    state_t state_q;
    logic                 req, mis, is_b, is_h;
    logic [3:0]           be_st;
    logic [word_size-1:0] wd_st, ext;
    logic [15:0]          sh;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic                 bus_req_q, bus_we_q, load_valid_q, misaligned_q;
    logic [3:0]           bus_be_q;
    logic [word_size-1:0] bus_addr_q, bus_wdata_q, load_data_q;
    assign req  = mem_read | mem_write;
    assign is_b = funct3[1:0] == 2'b00;
    assign is_h = funct3[1:0] == 2'b01;
    assign mis  = is_h ? address[0] : (is_b ? 1'b0 : |address[1:0]);
    assign stall = !rst && ((state_q == IDLE && req && !mis) || state_q == REQ || state_q == WAIT_R);
    assign be_st = is_b ? 4'b0001 << address[1:0] : (is_h ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    assign wd_st = is_b ? {4{write_data[7:0]}} : (is_h ? {2{write_data[15:0]}} : write_data);
    // Shift the addressed lane down to bit 0; halfword offsets are always 0 or 2.
    assign sh  = 16'(bus_rdata >> {off_q, 3'b000});
    assign ext = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] & sh[7]}}, sh[7:0]}
               : f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] & sh[15]}}, sh}
               : bus_rdata;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misaligned = misaligned_q;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          bus_error_q;
    assign bus_error = bus_error_q;
`else
    // Always 0; the comparison only keeps TIMEOUT_CYCLES referenced.
    assign bus_error = (TIMEOUT_CYCLES < 0);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_error_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req && mis) begin
                        misaligned_q <= 1'b1;
                    end else if (req) begin
                        state_q     <= REQ;
                        f3_q        <= funct3;
                        off_q       <= address[1:0];
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {address[word_size-1:2], 2'b00};
                        bus_be_q    <= mem_write ? be_st : 4'b1111;
                        bus_wdata_q <= mem_write ? wd_st : '0;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= bus_we_q ? DONE : WAIT_R;
`ifdef LSU_TIMEOUT_EN
                        cnt_q     <= '0;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus_req_q    <= 1'b0;
                        bus_error_q  <= 1'b1;
                        load_valid_q <= !bus_we_q;
                        load_data_q  <= bus_we_q ? load_data_q : '0;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
`endif
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        load_data_q  <= ext;
                        load_valid_q <= 1'b1;
                        state_q      <= DONE;
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus_error_q  <= 1'b1;
                        load_valid_q <= 1'b1;
                        load_data_q  <= '0;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
